// File: rtl/preif_ifetch_ctrl_if.sv
// Signal bundle between the fetch controller, the PC register, the instruction bus and the IF stage.
// The master modport is the fetch controller's view.
interface preif_ifetch_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              Flush;
  logic [PC_W-1:0]   PREIF_PC;
  logic              PREIF_Wr;
  logic              inst_req;
  logic [PC_W-1:0]   inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [INST_W-1:0] inst_rdata;
  logic              IF_Valid;
  logic              IF_Ready;
  logic [PC_W-1:0]   IF_PC;
  logic [INST_W-1:0] IF_Instr;
  logic              IF_AdEL;

  modport master (
    input  Flush, PREIF_PC, inst_addr_ok, inst_data_ok, inst_rdata, IF_Ready,
    output PREIF_Wr, inst_req, inst_addr, IF_Valid, IF_PC, IF_Instr, IF_AdEL
  );

  modport slave (
    output Flush, PREIF_PC, inst_addr_ok, inst_data_ok, inst_rdata, IF_Ready,
    input  PREIF_Wr, inst_req, inst_addr, IF_Valid, IF_PC, IF_Instr, IF_AdEL
  );
endinterface

// File: rtl/preif_ifetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM-like read, flush-kill of in-flight
// fetches, and a one-entry valid/ready register towards the IF stage.
module preif_ifetch_ctrl #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  preif_ifetch_ctrl_if.master  io
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]        r_state;
  logic              r_kill;
  logic [PC_W-1:0]   r_addr;
  logic              r_valid;
  logic [PC_W-1:0]   r_if_pc;
  logic [INST_W-1:0] r_if_instr;
  logic              r_adel;

  logic w_slot_free;
  logic w_aligned;
  logic w_idle_go;
  logic w_issue;
  logic w_misalign;
  logic w_load_data;
  logic w_req_hs_live;

  assign w_slot_free   = ~r_valid | io.IF_Ready;
  assign w_aligned     = (io.PREIF_PC[1:0] == 2'b00);
  assign w_idle_go     = (r_state == S_IDLE) & ~io.Flush & w_slot_free;
  assign w_issue       = w_idle_go & w_aligned;
  assign w_misalign    = w_idle_go & ~w_aligned;
  assign w_load_data   = (r_state == S_WAIT) & io.inst_data_ok & ~io.Flush;
  assign w_req_hs_live = (r_state == S_REQ) & io.inst_addr_ok & ~r_kill;

  // The PC advances at the address handshake: the fetched address is already held in r_addr.
  assign io.PREIF_Wr  = io.Flush | w_req_hs_live | w_misalign;
  assign io.inst_req  = (r_state == S_REQ);
  assign io.inst_addr = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kill  <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_addr  <= io.PREIF_PC;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // The request stays up until accepted; a flush only marks it for discard.
          if (io.inst_addr_ok) begin
            if (r_kill | io.Flush) begin
              r_kill  <= 1'b1;
              r_state <= S_DISCARD;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (io.Flush) begin
            r_kill <= 1'b1;
          end
        end
        S_WAIT: begin
          if (io.inst_data_ok) begin
            r_state <= S_IDLE;
          end else if (io.Flush) begin
            r_kill  <= 1'b1;
            r_state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (io.inst_data_ok) begin
            r_kill  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Flush wins over any load so a stale entry never reaches IF after a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
      r_adel     <= 1'b0;
    end else if (io.Flush) begin
      r_valid <= 1'b0;
    end else if (w_load_data) begin
      r_valid    <= 1'b1;
      r_if_pc    <= r_addr;
      r_if_instr <= io.inst_rdata;
      r_adel     <= 1'b0;
    end else if (w_misalign) begin
      r_valid    <= 1'b1;
      r_if_pc    <= io.PREIF_PC;
      r_if_instr <= '0;
      r_adel     <= 1'b1;
    end else if (r_valid & io.IF_Ready) begin
      r_valid <= 1'b0;
    end
  end

  assign io.IF_Valid = r_valid;
  assign io.IF_PC    = r_if_pc;
  assign io.IF_Instr = r_if_instr;
  assign io.IF_AdEL  = r_adel;

endmodule

// File: tb/tb_preif_ifetch_ctrl.sv
// Bench for preif_ifetch_ctrl: directed scenarios followed by random bus/flush/backpressure
// traffic, checked against a PC-stream model of which instructions IF must receive.
module tb_preif_ifetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  preif_ifetch_ctrl_if #(.PC_W(32), .INST_W(32)) bus();
  preif_ifetch_ctrl #(.PC_W(32), .INST_W(32)) dut (.clk(clk), .rst(rst), .io(bus));

  logic [31:0] pc, npc, exp_pc, pend_addr, prev_addr;
  logic        pending, prev_stall;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_deliv = 0;

  assign bus.PREIF_PC = pc;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h9BC8_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic fl, input logic aok, input logic dok, input logic rdy);
    bus.Flush        = fl;
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = dok ? mem(pend_addr) : 32'd0;
    bus.IF_Ready     = rdy;
    #1;
  endtask

  // Checks the current cycle against the model, advances one clock, updates the model.
  task automatic tick();
    logic wr, fl, hs_if, hs_a, dok;
    wr    = bus.PREIF_Wr;
    fl    = bus.Flush;
    hs_if = bus.IF_Valid & bus.IF_Ready;
    hs_a  = bus.inst_req & bus.inst_addr_ok;
    dok   = bus.inst_data_ok;
    if (bus.inst_req) chk1("one_outstanding", pending, 1'b0);
    if (prev_stall) begin
      chk1("req_held", bus.inst_req, 1'b1);
      chk("addr_held", bus.inst_addr, prev_addr);
    end
    if (hs_if && !fl) begin
      chk("entry_pc", bus.IF_PC, exp_pc);
      chk("entry_instr", bus.IF_Instr, (exp_pc[1:0] == 2'b00) ? mem(exp_pc) : 32'd0);
      chk1("entry_adel", bus.IF_AdEL, exp_pc[1:0] != 2'b00);
      n_deliv++;
    end
    prev_stall = bus.inst_req & ~bus.inst_addr_ok;
    prev_addr  = bus.inst_addr;
    @(posedge clk);
    #1;
    if (wr) pc = fl ? npc : pc + 32'd4;
    if (fl) exp_pc = npc;
    else if (hs_if) exp_pc = exp_pc + 32'd4;
    if (fl) chk1("flush_clears_valid", bus.IF_Valid, 1'b0);
    if (dok) pending = 1'b0;
    if (hs_a) begin
      pending   = 1'b1;
      pend_addr = prev_addr;
    end
  endtask

  initial begin
    pc = 32'd0; npc = 32'd0; exp_pc = 32'd0; pend_addr = 32'd0; prev_addr = 32'd0;
    pending = 1'b0; prev_stall = 1'b0;
    bus.Flush = 1'b0; bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
    bus.inst_rdata = 32'd0; bus.IF_Ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk1("rst_req", bus.inst_req, 1'b0);
    chk1("rst_valid", bus.IF_Valid, 1'b0);
    chk("rst_if_pc", bus.IF_PC, 32'd0);
    chk("rst_if_instr", bus.IF_Instr, 32'd0);
    chk1("rst_adel", bus.IF_AdEL, 1'b0);
    chk1("rst_wr", bus.PREIF_Wr, 1'b0);
    pc = 32'hBFC0_0000; exp_pc = pc;
    @(posedge clk); #1; rst = 1'b0;

    // Basic fetch
    set_in(0, 0, 0, 1); chk1("idle_wr", bus.PREIF_Wr, 1'b0); tick();
    set_in(0, 1, 0, 1);
    chk1("fetch_req", bus.inst_req, 1'b1);
    chk("fetch_addr", bus.inst_addr, 32'hBFC0_0000);
    chk1("fetch_wr", bus.PREIF_Wr, 1'b1);
    tick();
    set_in(0, 0, 1, 1);
    chk1("wait_req", bus.inst_req, 1'b0);
    chk1("wait_wr", bus.PREIF_Wr, 1'b0);
    tick();
    set_in(0, 0, 0, 0);
    chk1("fetch_valid", bus.IF_Valid, 1'b1);
    chk("fetch_if_pc", bus.IF_PC, 32'hBFC0_0000);
    chk("fetch_if_instr", bus.IF_Instr, 32'h2408_0001);
    chk1("fetch_adel", bus.IF_AdEL, 1'b0);
    tick();

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0);
      chk1("bp_no_req", bus.inst_req, 1'b0);
      chk1("bp_hold_valid", bus.IF_Valid, 1'b1);
      tick();
    end
    set_in(0, 0, 0, 1); tick();

    // Flush during REQ, handshake two cycles later
    npc = 32'hBFC0_0380;
    set_in(1, 0, 0, 1);
    chk1("bp_resume_req", bus.inst_req, 1'b1);
    chk("bp_resume_addr", bus.inst_addr, 32'hBFC0_0004);
    chk1("flush_wr", bus.PREIF_Wr, 1'b1);
    tick();
    set_in(0, 0, 0, 1); chk1("killed_no_wr", bus.PREIF_Wr, 1'b0); tick();
    set_in(0, 1, 0, 1);
    chk("killed_addr", bus.inst_addr, 32'hBFC0_0004);
    chk1("killed_hs_wr", bus.PREIF_Wr, 1'b0);
    tick();
    set_in(0, 0, 1, 1); chk1("discard_no_req", bus.inst_req, 1'b0); tick();
    set_in(0, 0, 0, 1); chk1("discard_drop", bus.IF_Valid, 1'b0); tick();

    // Flush in WAIT together with data_ok
    set_in(0, 1, 0, 1); chk("redir_addr", bus.inst_addr, 32'hBFC0_0380); tick();
    npc = 32'hBFC0_0380;
    set_in(1, 0, 1, 1); chk1("wait_flush_wr", bus.PREIF_Wr, 1'b1); tick();
    set_in(0, 0, 0, 1);
    chk1("wait_flush_drop", bus.IF_Valid, 1'b0);
    chk1("wait_flush_idle", bus.inst_req, 1'b0);
    tick();
    set_in(0, 1, 0, 1); chk("refetch_addr", bus.inst_addr, 32'hBFC0_0380); tick();
    set_in(0, 0, 1, 1); tick();

    // Misaligned PC
    npc = 32'hBFC0_0002;
    set_in(1, 0, 0, 1); chk("refetch_if_pc", bus.IF_PC, 32'hBFC0_0380); tick();
    set_in(0, 0, 0, 0);
    chk1("misalign_wr", bus.PREIF_Wr, 1'b1);
    chk1("misalign_no_req", bus.inst_req, 1'b0);
    tick();
    set_in(0, 0, 0, 0);
    chk1("misalign_valid", bus.IF_Valid, 1'b1);
    chk1("misalign_adel", bus.IF_AdEL, 1'b1);
    chk("misalign_if_pc", bus.IF_PC, 32'hBFC0_0002);
    chk("misalign_instr", bus.IF_Instr, 32'd0);
    chk1("misalign_req", bus.inst_req, 1'b0);
    tick();
    npc = 32'hBFC0_0000;
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 0, 1); tick();
    set_in(0, 1, 0, 1); tick();

    // Asynchronous reset pulse in WAIT, then in REQ
    set_in(0, 0, 0, 1);
    rst = 1'b1; #1;
    chk1("arst_req", bus.inst_req, 1'b0);
    chk1("arst_valid", bus.IF_Valid, 1'b0);
    pc = 32'hBFC0_0100; exp_pc = pc; pending = 1'b0; prev_stall = 1'b0;
    #1 rst = 1'b0;
    tick();
    set_in(0, 0, 0, 1);
    chk1("post_rst_req", bus.inst_req, 1'b1);
    chk("post_rst_addr", bus.inst_addr, 32'hBFC0_0100);
    rst = 1'b1; #1;
    chk1("arst_req_drop", bus.inst_req, 1'b0);
    pending = 1'b0; prev_stall = 1'b0;
    #1 rst = 1'b0;
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.Flush        = ($urandom_range(0, 15) == 0);
      npc              = 32'hBFC0_0000 + ($urandom_range(0, 1023) << 2)
                         + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      bus.inst_addr_ok = bus.inst_req & ($urandom_range(0, 1) == 1);
      bus.inst_data_ok = pending & ($urandom_range(0, 2) != 0);
      bus.inst_rdata   = bus.inst_data_ok ? mem(pend_addr) : $urandom();
      bus.IF_Ready     = ($urandom_range(0, 3) != 0);
      #1;
      tick();
    end
    chk1("liveness", n_deliv >= 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
